// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the stall/flush controller: FSM states,
// register index width and the stage control bundle.
package hazard_stall_unit_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int unsigned FETCH_CTRL_W = 3;  // PCWrite, IFID_Write, IFID_Flush
  localparam int unsigned EXEC_CTRL_W  = 2;  // IDEX_Bubble, Pipe_Freeze

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_freeze;
  } stage_ctrl_t;

  localparam int unsigned STAGE_CTRL_W = FETCH_CTRL_W + EXEC_CTRL_W;

  localparam stage_ctrl_t CTRL_FLOW     = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                            idex_bubble: 1'b0, pipe_freeze: 1'b0};
  localparam stage_ctrl_t CTRL_FREEZE   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                            idex_bubble: 1'b0, pipe_freeze: 1'b1};
  localparam stage_ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                            idex_bubble: 1'b1, pipe_freeze: 1'b0};
  localparam stage_ctrl_t CTRL_LU_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                            idex_bubble: 1'b1, pipe_freeze: 1'b0};

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: load-use bubbles, branch/jump flushes and
// whole-pipeline freeze while data memory is busy, with saturating counters.
module hazard_stall_unit #(
  parameter int unsigned REG_ADDR_W = hazard_stall_unit_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] IFID_Rs,
  input  logic [REG_ADDR_W-1:0] IFID_Rt,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt,
  input  logic                  IDEX_MemRead,
  input  logic                  Branch_Taken,
  input  logic                  Jump,
  input  logic                  Mem_Req,
  input  logic                  Mem_Ready,
  output logic                  PCWrite,
  output logic                  IFID_Write,
  output logic                  IFID_Flush,
  output logic                  IDEX_Bubble,
  output logic                  Pipe_Freeze,
  output logic [CNT_W-1:0]      Stall_Cnt,
  output logic [CNT_W-1:0]      Flush_Cnt
);
  import hazard_stall_unit_pkg::*;

  state_t      state, state_nxt;
  stage_ctrl_t ctrl, run_ctrl;
  logic        load_use, mem_miss;
  logic        run_stall, run_flush;
  logic        stall_inc, flush_inc;

  assign load_use = IDEX_MemRead && (IDEX_Rt != '0) &&
                    ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
  assign mem_miss = Mem_Req && !Mem_Ready;

  // Free-running pipeline decision, shared by RUN and the MEM_WAIT release cycle.
  always_comb begin
    run_ctrl  = CTRL_FLOW;
    run_stall = 1'b0;
    run_flush = 1'b0;
    if (Branch_Taken || Jump) begin
      run_ctrl  = CTRL_REDIRECT;
      run_flush = 1'b1;
    end else if (load_use) begin
      run_ctrl  = CTRL_LU_STALL;
      run_stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    ctrl      = CTRL_FLOW;
    state_nxt = state;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (reset) begin
      unique case (state)
        RUN: begin
          if (mem_miss) begin
            ctrl      = CTRL_FREEZE;
            state_nxt = MEM_WAIT;
            stall_inc = 1'b1;
          end else begin
            ctrl      = run_ctrl;
            stall_inc = run_stall;
            flush_inc = run_flush;
          end
        end
        MEM_WAIT: begin
          if (!Mem_Ready) begin
            ctrl      = CTRL_FREEZE;
            stall_inc = 1'b1;
          end else begin
            // Release cycle is not counted as a stall even if it bubbles.
            ctrl      = run_ctrl;
            state_nxt = RUN;
            flush_inc = run_flush;
          end
        end
      endcase
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign IFID_Write  = ctrl.ifid_write;
  assign IFID_Flush  = ctrl.ifid_flush;
  assign IDEX_Bubble = ctrl.idex_bubble;
  assign Pipe_Freeze = ctrl.pipe_freeze;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_inc),
    .count (Stall_Cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush_inc),
    .count (Flush_Cnt)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed vector table, saturation sequence and
// randomized stimulus against a behavioural model (16-bit and 4-bit counters).
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic       IDEX_MemRead, Branch_Taken, Jump, Mem_Req, Mem_Ready;

  logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze;
  logic [15:0] Stall_Cnt, Flush_Cnt;
  logic        pcw4, ifw4, iff4, bub4, frz4;
  logic [3:0]  stall4, flush4;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  hazard_stall_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IDEX_Rt(IDEX_Rt),
    .IDEX_MemRead(IDEX_MemRead), .Branch_Taken(Branch_Taken), .Jump(Jump),
    .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble), .Pipe_Freeze(Pipe_Freeze),
    .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
  );

  hazard_stall_unit #(.REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IDEX_Rt(IDEX_Rt),
    .IDEX_MemRead(IDEX_MemRead), .Branch_Taken(Branch_Taken), .Jump(Jump),
    .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready), .PCWrite(pcw4), .IFID_Write(ifw4),
    .IFID_Flush(iff4), .IDEX_Bubble(bub4), .Pipe_Freeze(frz4),
    .Stall_Cnt(stall4), .Flush_Cnt(flush4)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  rs, rt, xrt;
    logic        mr, br, jp, rq, rd;
    logic [4:0]  ctrl;  // {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze}
    int unsigned s, f;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic [4:0] xrt,
                              logic mr, logic br, logic jp, logic rq, logic rd,
                              logic [4:0] ctrl, int unsigned s, int unsigned f);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.xrt = xrt; v.mr = mr; v.br = br; v.jp = jp;
    v.rq = rq; v.rd = rd; v.ctrl = ctrl; v.s = s; v.f = f;
    return v;
  endfunction

  function automatic int unsigned sat(int unsigned n, int unsigned max);
    return (n > max) ? max : n;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; IFID_Rs = v.rs; IFID_Rt = v.rt; IDEX_Rt = v.xrt;
    IDEX_MemRead = v.mr; Branch_Taken = v.br; Jump = v.jp; Mem_Req = v.rq; Mem_Ready = v.rd;
  endtask

  // Inputs are already driven; sample at the falling edge, then advance one cycle.
  task automatic check_cycle(input string tag, input logic [4:0] ec,
                             input int unsigned s16, input int unsigned f16,
                             input int unsigned s4, input int unsigned f4);
    @(negedge clk);
    chk({tag, " ctrl16"}, {27'd0, PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze}, {27'd0, ec});
    chk({tag, " ctrl4"}, {27'd0, pcw4, ifw4, iff4, bub4, frz4}, {27'd0, ec});
    chk({tag, " stall16"}, {16'd0, Stall_Cnt}, s16);
    chk({tag, " flush16"}, {16'd0, Flush_Cnt}, f16);
    chk({tag, " stall4"}, {28'd0, stall4}, s4);
    chk({tag, " flush4"}, {28'd0, flush4}, f4);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    bit          m_wait;
    int unsigned m_s, m_f;

    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0));  // reset controls
    tbl.push_back(mk(1, 8, 0, 8, 1, 0, 0, 0, 0, 5'b00010, 0, 0));  // load-use via Rs
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 5'b11000, 1, 0));  // r0 is no hazard
    tbl.push_back(mk(1, 3, 9, 9, 1, 0, 0, 0, 0, 5'b00010, 1, 0));  // load-use via Rt
    tbl.push_back(mk(1, 8, 0, 8, 1, 1, 0, 0, 0, 5'b11110, 2, 0));  // branch overrides LU
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11110, 2, 1));  // jump
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 2, 2));  // miss
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 3, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 4, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11000, 5, 2));  // release
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5, 2));  // back in RUN
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 5'b00001, 5, 2));  // miss beats branch
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 5'b00001, 6, 2));  // branch held in wait
    tbl.push_back(mk(1, 8, 0, 8, 1, 1, 0, 1, 1, 5'b11110, 7, 2));  // branch acted on at release
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 7, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 7, 3));  // enter wait
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11000, 8, 3));  // reset mid-wait
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0));  // RUN, counters cleared

    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0);
    drive(v);
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      check_cycle($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].s, tbl[i].f,
                  sat(tbl[i].s, 15), sat(tbl[i].f, 15));
    end

    // Twenty back-to-back load-use stalls: the 4-bit counter must pin at 15.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      drive(mk(1, 5, 0, 5, 1, 0, 0, 0, 0, 5'b00010, 0, 0));
      check_cycle($sformatf("lu_sat%0d", i), 5'b00010, i, 0, sat(i, 15), 0);
    end
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0));
    check_cycle("sat_end", 5'b11000, 20, 0, 15, 0);

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0));
    check_cycle("rnd_reset", 5'b11000, 20, 0, 15, 0);

    m_wait = 1'b0;
    m_s = 0;
    m_f = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] ec;
      bit         lu, redirect, s_inc, f_inc, nxt_wait;
      v.rst = ($urandom_range(0, 49) != 0);
      v.rs  = 5'($urandom_range(0, 3));
      v.rt  = 5'($urandom_range(0, 3));
      v.xrt = 5'($urandom_range(0, 3));
      v.mr  = 1'($urandom_range(0, 1));
      v.br  = ($urandom_range(0, 7) == 0);
      v.jp  = ($urandom_range(0, 7) == 0);
      v.rq  = ($urandom_range(0, 2) == 0);
      v.rd  = 1'($urandom_range(0, 1));
      drive(v);

      lu       = v.mr && (v.xrt != 0) && (v.xrt == v.rs || v.xrt == v.rt);
      redirect = v.br || v.jp;
      s_inc    = 1'b0;
      f_inc    = 1'b0;
      nxt_wait = 1'b0;
      ec       = 5'b11000;
      if (v.rst) begin
        if (m_wait ? !v.rd : (v.rq && !v.rd)) begin
          ec = 5'b00001; s_inc = 1'b1; nxt_wait = 1'b1;
        end else if (redirect) begin
          ec = 5'b11110; f_inc = 1'b1;
        end else if (lu) begin
          ec = 5'b00010; s_inc = !m_wait;
        end
      end

      check_cycle($sformatf("rnd%0d", n), ec, sat(m_s, 65535), sat(m_f, 65535),
                  sat(m_s, 15), sat(m_f, 15));

      if (!v.rst) begin
        m_wait = 1'b0; m_s = 0; m_f = 0;
      end else begin
        m_wait = nxt_wait;
        if (s_inc) m_s++;
        if (f_inc) m_f++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
